// File: rtl/aes_dec_key_sched_pkg.sv
// rtl/aes_dec_key_sched_pkg.sv - shared constants, types and helpers for the AES-128 decryption key schedule
package aes_dec_key_sched_pkg;

  localparam int NR    = 10;
  localparam int NK    = NR + 1;
  localparam int KEYW  = 128;
  localparam int WORDW = 32;

  typedef enum logic [1:0] {
    IDLE,
    EXPAND,
    READY
  } state_t;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  // Rotate a word left by one byte; byte 0 is the most significant.
  function automatic logic [0:WORDW-1] rot_word(input logic [0:WORDW-1] w);
    return {w[8:31], w[0:7]};
  endfunction

  // Byte-wise S-box substitution of a whole word.
  function automatic logic [0:WORDW-1] sub_word(input logic [0:WORDW-1] w);
    return {SBOX[w[0:7]], SBOX[w[8:15]], SBOX[w[16:23]], SBOX[w[24:31]]};
  endfunction

endpackage

// File: rtl/aes_dec_key_sched_if.sv
// rtl/aes_dec_key_sched_if.sv - control, round-constant and read-port signals of the key schedule
interface aes_dec_key_sched_if;
  import aes_dec_key_sched_pkg::*;

  logic              start;
  logic [0:KEYW-1]   key_in;
  logic [0:3]        keyid;
  logic [0:7]        R0;
  logic [0:7]        R1;
  logic [0:7]        R2;
  logic [0:7]        R3;
  logic              busy;
  logic              ready;
  logic              rd_en;
  logic [0:3]        rd_idx;
  logic [0:KEYW-1]   rd_key;
  logic              rd_valid;

  modport slave (
    input  start, key_in, R0, R1, R2, R3, rd_en, rd_idx,
    output keyid, busy, ready, rd_key, rd_valid
  );

  modport master (
    output start, key_in, R0, R1, R2, R3, rd_en, rd_idx,
    input  keyid, busy, ready, rd_key, rd_valid
  );

endinterface

// File: rtl/aes_sbox.sv
// rtl/aes_sbox.sv - combinational AES forward S-box byte substitution
module aes_sbox
  import aes_dec_key_sched_pkg::*;
(
  input  logic [0:7] in_byte,
  output logic [0:7] out_byte
);

  assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/aes_dec_key_sched.sv
// rtl/aes_dec_key_sched.sv - sequential AES-128 key expansion with an 11-entry round-key buffer and registered read port
module aes_dec_key_sched
  import aes_dec_key_sched_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  aes_dec_key_sched_if.slave bus
);

  state_t            state;
  state_t            state_nxt;
  logic [0:3]        keyid_q;
  logic [0:3]        keyid_nxt;
  logic              load_key;
  logic              exp_step;
  logic              rd_fire;
  logic [0:KEYW-1]   keys [NK];
  logic [0:3]        prev_idx;
  logic [0:KEYW-1]   prev_key;
  logic [0:WORDW-1]  w0, w1, w2, w3;
  logic [0:WORDW-1]  rot_w, sub_w, rcon_w, t_w;
  logic [0:WORDW-1]  n0, n1, n2, n3;
  logic [0:KEYW-1]   rd_key_q;
  logic              rd_valid_q;

  // Round r derives from entry r-1; the guard keeps the index in range while keyid idles at 0.
  assign prev_idx = (keyid_q == 4'd0) ? 4'd0 : keyid_q - 4'd1;
  assign prev_key = keys[prev_idx];

  assign w0 = prev_key[0:31];
  assign w1 = prev_key[32:63];
  assign w2 = prev_key[64:95];
  assign w3 = prev_key[96:127];

  assign rot_w = rot_word(w3);

  for (genvar i = 0; i < 4; i++) begin : g_sub
    aes_sbox u_sbox (
      .in_byte  (rot_w[8*i +: 8]),
      .out_byte (sub_w[8*i +: 8])
    );
  end

  // The round-constant block's full word is used; bytes R1..R3 are not masked.
  assign rcon_w = {bus.R0, bus.R1, bus.R2, bus.R3};
  assign t_w    = sub_w ^ rcon_w;
  assign n0     = w0 ^ t_w;
  assign n1     = w1 ^ n0;
  assign n2     = w2 ^ n1;
  assign n3     = w3 ^ n2;

  assign rd_fire = (state == READY) && bus.rd_en;

  // State and round-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      keyid_q <= 4'd0;
    end else begin
      state   <= state_nxt;
      keyid_q <= keyid_nxt;
    end
  end

  // Next-state logic: accept start in IDLE or READY, step one round per cycle in EXPAND.
  always_comb begin
    state_nxt = state;
    keyid_nxt = keyid_q;
    load_key  = 1'b0;
    exp_step  = 1'b0;
    unique case (state)
      IDLE, READY: begin
        if (bus.start) begin
          load_key  = 1'b1;
          keyid_nxt = 4'd1;
          state_nxt = EXPAND;
        end
      end
      EXPAND: begin
        exp_step = 1'b1;
        if (keyid_q == 4'(NR)) begin
          keyid_nxt = 4'd0;
          state_nxt = READY;
        end else begin
          keyid_nxt = keyid_q + 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        keyid_nxt = 4'd0;
      end
    endcase
  end

  // Round-key buffer: entry 0 takes the cipher key, entries 1..10 the expanded keys.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NK; i++) begin
        keys[i] <= '0;
      end
    end else if (load_key) begin
      keys[0] <= bus.key_in;
    end else if (exp_step) begin
      keys[keyid_q] <= {n0, n1, n2, n3};
    end
  end

  // Registered read port; a read coinciding with a restart still sees the old keys.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_key_q   <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_fire;
      if (rd_fire) begin
        rd_key_q <= (bus.rd_idx <= 4'(NR)) ? keys[bus.rd_idx] : '0;
      end
    end
  end

  assign bus.keyid    = keyid_q;
  assign bus.busy     = (state == EXPAND);
  assign bus.ready    = (state == READY);
  assign bus.rd_key   = rd_key_q;
  assign bus.rd_valid = rd_valid_q;

endmodule

// File: doc/aes_dec_key_sched.md
Name: aes_dec_key_sched

Overview:
- Sequential key-schedule engine for the AES-128 decryption path. It sits directly downstream of the per-round round-constant block and consumes its R0..R3 bytes.
- It drives that block's keyid input and expands the 128-bit cipher key into round keys 0..10 over ten clock cycles. The keys are held in an internal 11-entry buffer.
- Once ready, it serves any round key to the inverse-cipher datapath through a registered read port. Decryption reads indices 10 down to 0.

Parameters:
- NR, 10, number of expansion rounds; fixed for AES-128. Other values are unsupported.
- NK, 11, round-key buffer depth (NR+1).

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  one-cycle request to expand key_in
- key_in  input  [0:127]  cipher key; bit 0 is the MSB; sampled when start is accepted
- keyid  output  [0:3]  round selector driven to the round-constant block; 0 when not expanding
- R0, R1, R2, R3  input  [0:7] each  round-constant bytes returned for the current keyid; combinational, same cycle
- busy  output  1  high while expanding
- ready  output  1  high when all 11 keys are valid
- rd_en  input  1  read request
- rd_idx  input  [0:3]  round-key index, 0..10
- rd_key  output  [0:127]  registered read data
- rd_valid  output  1  high one cycle after an accepted read

Behaviour:
- Reset, applied at any time including mid-expansion:
  - state=IDLE; keyid=0, busy=0, ready=0, rd_valid=0, rd_key=0.
  - Buffer contents are cleared to 0.
- States: IDLE, EXPAND, READY.
- IDLE:
  - start=1 writes key_in to entry 0, sets keyid=1 and busy=1, and moves to EXPAND.
- EXPAND, current round r=keyid, previous key words w0..w3 = entry r-1:
  - t = SubWord(RotWord(w3)) XOR {R0,R1,R2,R3}.
  - n0=w0^t, n1=w1^n0, n2=w2^n1, n3=w3^n2.
  - {n0..n3} is written to entry r at the clock edge.
  - If r<10: keyid increments.
  - If r=10: keyid=0, busy=0, ready=1, state moves to READY.
- R0..R3 are XORed in full as a 32-bit word. The block does not force R1..R3 to zero.
- Latency: start sampled at edge t → ready=1 visible after edge t+10. Exactly 11 edges, including the entry-0 write.
- start while in EXPAND is ignored; expansion continues unchanged.
- start while in READY restarts expansion:
  - ready=0 and busy=1 from the next cycle.
  - Entry 0 is overwritten with the new key_in.
  - Stale entries stay readable only until overwritten. Reads are not accepted because ready=0.
- Reads:
  - Accepted only when ready=1 and rd_en=1.
  - rd_key is the entry for rd_idx on the following cycle, with rd_valid=1 for that cycle.
  - rd_idx>10 gives rd_key=0 with rd_valid=1.
  - rd_en while not ready gives rd_valid=0 and leaves rd_key unchanged.
- Simultaneous start and rd_en in READY: the read is served from the old keys and the restart proceeds in parallel.
- Back-to-back reads are supported every cycle.
- All arithmetic is bytewise XOR. There are no carries.

Decomposition:
- Shared package holds:
  - the AES S-box constant table;
  - constants NR=10 and NK=11, KEYW=128, WORDW=32;
  - the state encoding typedef {IDLE, EXPAND, READY};
  - RotWord and SubWord helper functions.
- One natural sub-module: aes_sbox, a combinational byte substitution. It is instantiated four times for SubWord.

Test Plan:
- Bench contains an Rcon model returning {rcon[keyid],00,00,00}.
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start → ready after 11 cycles; rd_idx 1 → a0fafe1788542cb123a339392a6c7605; rd_idx 10 → d014f9a8c9ee2589e13f0cc8b6630ca6; rd_idx 0 → key_in.
- Key 000102030405060708090a0b0c0d0e0f → rd_idx 10 returns 13111d7fe3944a17f307a78b4d2b30c5. keyid sequence observed on the port is 1,2,…,10,0.
- Assert rst at cycle 5 of expansion → next cycle busy=0, ready=0, keyid=0; a subsequent start gives the correct full expansion.
- start repeated during EXPAND → ignored, result identical to the first key. start in READY with a new key → ready drops for 11 cycles, then the new keys are read back.
- Reads: rd_en before ready → rd_valid=0; in READY, rd_idx 15 → rd_key=0 with rd_valid=1; consecutive reads 10,9,…,0 return the correct keys on consecutive cycles.
